pipe_stage_reg: RTL

- Parametrised, elastic successor to the fixed EX/MEM pipeline register.
- Carries ALU result, store data, PC, destination register and a control bundle between two pipeline stages.
- Adds a valid/ready handshake, synchronous flush and an optional one-entry skid buffer, so back-pressure (stall) and kill (branch/exception) are handled inside the stage.
- Instantiated at EX/MEM first; reusable at ID/EX and MEM/WB.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_skid_buf.sv | 34 +++
 rtl/pipe_stage_reg.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for elastic pipeline stage registers.
// Default-width payload bundle plus control-bundle bit positions.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN_DEF   = 32;
    localparam int CTRL_W_DEF = 8;

    localparam int CTRL_MEM_RD    = 0;
    localparam int CTRL_MEM_WR    = 1;
    localparam int CTRL_REG_WR    = 2;
    localparam int CTRL_WB_SEL_LO = 3;
    localparam int CTRL_WB_SEL_HI = 4;

    typedef struct packed {
        logic [XLEN_DEF-1:0]   alu_out;
        logic [XLEN_DEF-1:0]   rs2_data;
        logic [XLEN_DEF-1:0]   pc;
        logic [REG_ADDR_W-1:0] rd;
        logic [CTRL_W_DEF-1:0] ctrl;
    } stage_payload_t;

    function automatic logic [1:0] bit_sum3(
        input logic a,
        input logic b,
        input logic c
    );
        return 2'(a) + 2'(b) + 2'(c);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Single-entry skid register that catches a beat while the main
// register is stalled; cleared by flush or when drained into main.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (load)
                valid <= 1'b1;
            else if (pop)
                valid <= 1'b0;
            if (!flush && load)
                dout <= din;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready, synchronous flush,
// optional skid entry and a saturating flush-drop counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       alu_out_in,
    input  logic [XLEN-1:0]       rs2_data_in,
    input  logic [XLEN-1:0]       current_pc_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [CTRL_W-1:0]     ctrl_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       alu_out_out,
    output logic [XLEN-1:0]       rs2_data_out,
    output logic [XLEN-1:0]       current_pc_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [CTRL_W-1:0]     ctrl_out,
    input  logic                  flush,
    output logic [1:0]            occ,
    output logic [CNT_W-1:0]      drop_cnt
);

    typedef struct packed {
        logic [XLEN-1:0]       alu_out;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rd;
        logic [CTRL_W-1:0]     ctrl;
    } payload_t;

    localparam bit HAS_SKID = (SKID != 0);

    payload_t       in_pl;
    payload_t       main_q;
    payload_t       skid_q;
    logic           out_valid_q;
    logic           skid_valid;
    logic           up;
    logic           dn;
    logic           skid_load;
    logic           skid_pop;
    logic           main_load;
    logic           ov_nxt;
    logic           sv_nxt;
    logic [1:0]     drop_add;
    logic [CNT_W:0] drop_sum;

    assign in_pl = '{
        alu_out:  alu_out_in,
        rs2_data: rs2_data_in,
        pc:       current_pc_in,
        rd:       rd_in,
        ctrl:     ctrl_in
    };

    generate
        if (HAS_SKID) begin : g_skid
            pipe_skid_buf #(
                .W($bits(payload_t))
            ) u_skid (
                .clk  (clk),
                .rst  (rst),
                .flush(flush),
                .load (skid_load),
                .pop  (skid_pop),
                .din  (in_pl),
                .valid(skid_valid),
                .dout (skid_q)
            );
            assign in_ready = !skid_valid;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_q     = '0;
            assign in_ready   = !out_valid_q || out_ready;
        end
    endgenerate

    assign up = in_valid && in_ready;
    assign dn = out_valid_q && out_ready;

    // A beat lands in skid only when main is full and not draining.
    assign skid_load = HAS_SKID && up && out_valid_q && !out_ready;
    assign skid_pop  = dn && skid_valid;
    assign main_load = !flush && (skid_pop || (up && !skid_load));

    always_comb begin
        ov_nxt = out_valid_q;
        if (flush)
            ov_nxt = 1'b0;
        else if (main_load)
            ov_nxt = 1'b1;
        else if (dn)
            ov_nxt = 1'b0;
    end

    always_comb begin
        sv_nxt = skid_valid;
        if (flush)
            sv_nxt = 1'b0;
        else if (skid_load)
            sv_nxt = 1'b1;
        else if (skid_pop)
            sv_nxt = 1'b0;
    end

    // A beat leaving downstream in the flush cycle is delivered.
    assign drop_add = bit_sum3(out_valid_q && !out_ready, skid_valid, up);
    assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(drop_add);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            main_q      <= '0;
            occ         <= 2'd0;
            drop_cnt    <= '0;
        end else begin
            out_valid_q <= ov_nxt;
            occ         <= 2'(ov_nxt) + 2'(sv_nxt);
            if (main_load)
                main_q <= skid_pop ? skid_q : in_pl;
            if (flush)
                drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    assign out_valid      = out_valid_q;
    assign alu_out_out    = main_q.alu_out;
    assign rs2_data_out   = main_q.rs2_data;
    assign current_pc_out = main_q.pc;
    assign rd_out         = main_q.rd;
    assign ctrl_out       = main_q.ctrl;

endmodule
